// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and the decoder: FSM encodings, NOP, opcodes.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/next_pc_gen.sv
// Next-PC selection for an accepted instruction, with word-alignment check.
module next_pc_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            pc_src,
    input  logic            pc_jalr,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    // jalr beats pc_src; sums wrap silently at the top of the address space
    always_comb begin
        next_pc = pc + XLEN'(4);
        if (pc_jalr) begin
            next_pc = {jalr_target[XLEN-1:1], 1'b0};
        end else if (pc_src) begin
            next_pc = pc + imm_ext;
        end
    end

    // bit 0 is always clear for jalr; bit 1 set means not word aligned
    assign misaligned = next_pc[1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem fetch, hold until core accepts.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned    MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            core_ready,
    input  logic            pc_src,
    input  logic            pc_jalr,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7_b5,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_err
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    fetch_state_t      state, state_next;
    logic [XLEN-1:0]   pc_next, instr_next;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
    logic [XLEN-1:0]   target;
    logic              target_misaligned;

    next_pc_gen #(.XLEN(XLEN)) u_next_pc_gen (
        .pc          (pc),
        .imm_ext     (imm_ext),
        .jalr_target (jalr_target),
        .pc_src      (pc_src),
        .pc_jalr     (pc_jalr),
        .next_pc     (target),
        .misaligned  (target_misaligned)
    );

    // Next-state, next-pc, instruction capture and timeout counting
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        instr_next    = instr;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_IDLE: begin
                state_next = ST_REQ;
            end
            ST_REQ: begin
                if (imem_rvalid) begin
                    instr_next = imem_rdata;
                    state_next = ST_VALID;
                end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                    state_next = ST_ERR;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            ST_VALID: begin
                if (core_ready) begin
                    if (target_misaligned) begin
                        state_next = ST_ERR;
                    end else begin
                        pc_next       = target;
                        wait_cnt_next = '0;
                        state_next    = ST_REQ;
                    end
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= XLEN'(NOP_INSTR);
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            wait_cnt    <= wait_cnt_next;
            imem_req    <= (state_next == ST_REQ);
            instr_valid <= (state_next == ST_VALID);
            fetch_err   <= (state_next == ST_ERR);
        end
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);
    assign op        = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a transaction-level PC model.
module tb_fetch_unit;

    localparam int unsigned MAX_WAIT = 15;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        core_ready;
    logic        pc_src;
    logic        pc_jalr;
    logic [31:0] imm_ext;
    logic [31:0] jalr_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .core_ready  (core_ready),
        .pc_src      (pc_src),
        .pc_jalr     (pc_jalr),
        .imm_ext     (imm_ext),
        .jalr_target (jalr_target),
        .instr       (instr),
        .instr_valid (instr_valid),
        .op          (op),
        .funct3      (funct3),
        .funct7_b5   (funct7_b5),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_redirect();
        core_ready  = 1'($urandom_range(0, 1));
        pc_src      = 1'($urandom_range(0, 1));
        pc_jalr     = 1'($urandom_range(0, 1));
        imm_ext     = $urandom;
        jalr_target = $urandom;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},   32'(imem_req),    32'h0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_err"},   32'(fetch_err),   32'h0);
        chk({tag, "_pc"},    pc,               32'h0);
        chk({tag, "_instr"}, instr,            NOP);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        imem_rvalid = 1'b0;
        core_ready  = 1'b0;
        tick();
        tick();
        rst  = 1'b0;
        m_pc = 32'h0;
    endtask

    // Expects the DUT to have just entered a fetch request
    task automatic do_fetch(input logic [31:0] data, input int lat);
        chk("req_asserted", 32'(imem_req), 32'h1);
        chk("req_addr", imem_addr, m_pc);
        for (int i = 0; i < lat; i++) begin
            imem_rvalid = 1'b0;
            scramble_redirect();
            tick();
        end
        if (lat > 0) begin
            chk("wait_no_err", 32'(fetch_err), 32'h0);
            chk("wait_pc_stable", pc, m_pc);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        core_ready  = 1'b0;
        pc_src      = 1'b0;
        pc_jalr     = 1'b0;
        tick();
        imem_rvalid = 1'b0;
        m_instr     = data;
        chk("fetched_valid", 32'(instr_valid), 32'h1);
        chk("fetched_instr", instr, data);
        chk("fetched_op", 32'(op), 32'(data[6:0]));
        chk("fetched_funct3", 32'(funct3), 32'(data[14:12]));
        chk("fetched_f7b5", 32'(funct7_b5), 32'(data[30]));
        chk("fetched_pc", pc, m_pc);
        chk("fetched_pc4", pc_plus4, m_pc + 32'd4);
        chk("fetched_req_low", 32'(imem_req), 32'h0);
    endtask

    // Expects the DUT to be holding an instruction; ends in the post-accept bubble or in error
    task automatic do_accept(input logic src, input logic jalr, input logic [31:0] imm,
                             input logic [31:0] jt, input int hold);
        logic [31:0] tgt;
        for (int i = 0; i < hold; i++) begin
            core_ready  = 1'b0;
            pc_src      = 1'($urandom_range(0, 1));
            pc_jalr     = 1'($urandom_range(0, 1));
            imm_ext     = $urandom;
            jalr_target = $urandom;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            tick();
            chk("hold_valid", 32'(instr_valid), 32'h1);
            chk("hold_instr", instr, m_instr);
            chk("hold_pc", pc, m_pc);
        end
        imem_rvalid = 1'b0;
        core_ready  = 1'b1;
        pc_src      = src;
        pc_jalr     = jalr;
        imm_ext     = imm;
        jalr_target = jt;
        tick();
        core_ready = 1'b0;
        pc_src     = 1'b0;
        pc_jalr    = 1'b0;
        if (jalr)     tgt = jt & 32'hFFFF_FFFE;
        else if (src) tgt = m_pc + imm;
        else          tgt = m_pc + 32'd4;
        if (tgt[1]) begin
            chk("misalign_err", 32'(fetch_err), 32'h1);
            chk("misalign_valid", 32'(instr_valid), 32'h0);
            chk("misalign_req", 32'(imem_req), 32'h0);
            chk("misalign_pc", pc, m_pc);
        end else begin
            m_pc = tgt;
            chk("bubble_valid", 32'(instr_valid), 32'h0);
            chk("bubble_req", 32'(imem_req), 32'h1);
            chk("bubble_addr", imem_addr, m_pc);
            chk("bubble_err", 32'(fetch_err), 32'h0);
        end
    endtask

    initial begin
        int kind;
        logic [31:0] imm_r, jt_r;

        // Reset with rvalid tied high; first fetch completes in one cycle
        rst = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        core_ready  = 1'b0;
        pc_src      = 1'b0;
        pc_jalr     = 1'b0;
        imm_ext     = 32'h0;
        jalr_target = 32'h0;
        m_pc        = 32'h0;
        m_instr     = NOP;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values("rst_idle");
        imem_rvalid = 1'b1;
        tick();
        do_fetch(32'h0050_0093, 0);
        chk("first_op", 32'(op), 32'h13);

        // Sequential fetches 4, 8, C, 10
        for (int i = 0; i < 4; i++) begin
            do_accept(1'b0, 1'b0, 32'h0, 32'h0, 1);
            do_fetch($urandom, 0);
        end
        chk("seq_pc", pc, 32'h10);

        // Backward branch and jalr (jalr beats pc_src, bit 0 cleared)
        do_accept(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 0);
        chk("branch_addr", imem_addr, 32'h08);
        do_fetch($urandom, 2);
        do_accept(1'b1, 1'b1, 32'h40, 32'h101, 2);
        chk("jalr_addr", imem_addr, 32'h100);
        do_fetch($urandom, MAX_WAIT);

        // Misaligned branch target, then sticky error ignores everything
        do_accept(1'b1, 1'b0, 32'h2, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            scramble_redirect();
            imem_rvalid = 1'b1;
            tick();
            chk("err_sticky", 32'(fetch_err), 32'h1);
            chk("err_req", 32'(imem_req), 32'h0);
            chk("err_valid", 32'(instr_valid), 32'h0);
            chk("err_pc", pc, 32'h100);
        end
        core_ready = 1'b0;
        reset_dut();
        check_reset_values("rst_after_misalign");

        // Timeout: MAX_WAIT silent cycles are tolerated, one more raises the error
        tick();
        chk("to_req", 32'(imem_req), 32'h1);
        imem_rvalid = 1'b0;
        for (int i = 0; i < int'(MAX_WAIT); i++) tick();
        chk("to_edge_err", 32'(fetch_err), 32'h0);
        chk("to_edge_req", 32'(imem_req), 32'h1);
        tick();
        chk("to_err", 32'(fetch_err), 32'h1);
        chk("to_req_low", 32'(imem_req), 32'h0);
        chk("to_valid_low", 32'(instr_valid), 32'h0);
        reset_dut();
        check_reset_values("rst_after_timeout");

        // Reset mid-fetch with a late rvalid that must be ignored
        tick();
        do_fetch(32'h0000_0093, 0);
        do_accept(1'b1, 1'b0, 32'h20, 32'h0, 0);
        imem_rvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        m_pc = 32'h0;
        chk("midrst_valid", 32'(instr_valid), 32'h0);
        chk("midrst_instr", instr, NOP);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_req", 32'(imem_req), 32'h1);

        // Randomized transactions with aligned targets
        for (int n = 0; n < 40; n++) begin
            do_fetch($urandom, $urandom_range(0, MAX_WAIT));
            kind  = $urandom_range(0, 2);
            imm_r = $urandom & 32'hFFFF_FFFC;
            jt_r  = $urandom & 32'hFFFF_FFFD;
            case (kind)
                0:       do_accept(1'b0, 1'b0, imm_r, jt_r, $urandom_range(0, 3));
                1:       do_accept(1'b1, 1'b0, imm_r, jt_r, $urandom_range(0, 3));
                default: do_accept(1'($urandom_range(0, 1)), 1'b1, imm_r, jt_r, $urandom_range(0, 3));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
